// File: rtl/alu_bitserial_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op codes, FSM states,
// and the bit-counter width helper.
package alu_bitserial_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/alu_bitserial_shreg.sv
// WIDTH-bit register with parallel load and shift-right; serial data enters
// at the MSB and leaves from the LSB. Load has priority over shift.
module alu_bitserial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i)       data_d = d_i;
    else if (shift_i) data_d = {sin_i, data_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q_o    = data_q;
  assign sout_o = data_q[0];

endmodule

// File: rtl/alu_bitserial_ctrl.sv
// Bit-serial sequencer around an external 1-bit ALU slice, LSB first with COUT
// chained into the next CIN. Optional zero/ovf flags via ALU_BITSERIAL_FLAGS_EN.
module alu_bitserial_ctrl
  import alu_bitserial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef ALU_BITSERIAL_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_f1,
  output logic             alu_f0,
  input  logic             alu_res,
  input  logic             alu_cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [1:0]      op_q;
  logic            busy_q;
  logic            done_q;
  logic            cout_q;
  logic            zero_q;
  logic            ovf_q;

  logic             accept;
  logic             run;
  logic             addsub;
  logic             a_lsb;
  logic             b_lsb;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             res_sout;
  logic [WIDTH-1:0] res_final;

  assign accept    = (state_q == IDLE) && start;
  assign run       = (state_q == RUN);
  assign addsub    = ~op_q[1];
  assign res_final = {alu_res, res_q[WIDTH-1:1]};

  alu_bitserial_shreg #(.WIDTH(WIDTH)) u_sh_a (
    .clk(clk), .rst(rst), .load_i(accept), .d_i(opa), .shift_i(run),
    .sin_i(1'b0), .q_o(a_q), .sout_o(a_lsb)
  );

  alu_bitserial_shreg #(.WIDTH(WIDTH)) u_sh_b (
    .clk(clk), .rst(rst), .load_i(accept), .d_i(opb), .shift_i(run),
    .sin_i(1'b0), .q_o(b_q), .sout_o(b_lsb)
  );

  alu_bitserial_shreg #(.WIDTH(WIDTH)) u_sh_res (
    .clk(clk), .rst(rst), .load_i(1'b0), .d_i('0), .shift_i(run),
    .sin_i(alu_res), .q_o(res_q), .sout_o(res_sout)
  );

  // Operand shift registers are only consumed through their LSB.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, res_sout, zero_q, ovf_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            carry_q <= (op == OP_SUB);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= alu_cout;
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB, alu_cout the carry out.
            cout_q  <= addsub & alu_cout;
            zero_q  <= (res_final == '0);
            ovf_q   <= addsub & (carry_q ^ alu_cout);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = res_q;
  assign cout    = cout_q;
  assign alu_a   = run & a_lsb;
  assign alu_b   = run & b_lsb;
  assign alu_cin = run & addsub & carry_q;
  assign alu_f1  = run & op_q[1];
  assign alu_f0  = run & op_q[0];

`ifdef ALU_BITSERIAL_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule
